// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if
//   Connects the ALU control sequencer to the bit-serial subtractor.
//   master : sequencer side (drives start/a/b, observes status and result)
//   slave  : subtractor side
// Signals:
//   start        launch request, sampled only while the subtractor is idle
//   a, b         minuend / subtrahend, captured on the accepting edge
//   busy         high while bits are being processed
//   done         one-cycle completion pulse
//   diff         a - b modulo 2^WIDTH
//   borrow       final borrow (a < b unsigned)
//   v, z         signed overflow / zero flags
interface serial_subtractor_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             v;
    logic             z;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, v, z
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, v, z
    );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial two's-complement subtractor: diff = a - b, one bit per clock,
//   LSB first, using a single full-subtractor cell and a registered borrow.
//   An operation takes WIDTH cycles from the accepting edge to done, plus one
//   DONE cycle before the block is idle again (WIDTH+2 cycles per operation).
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset; aborts any operation in flight
//   bus    serial_subtractor_if.slave (start/a/b in; busy/done/diff/borrow/v/z out)
// Configuration:
//   SERIAL_SUB_FLAGS_EN  when defined, the v (signed overflow) and z (zero)
//                        flags are computed; otherwise both are tied to 0 and
//                        the operand MSB capture registers are not built.
module serial_subtractor #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);

    localparam int             CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sa, sb, sd;
    logic             br;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;

    // Full-subtractor cell on the current LSBs.
    logic             x, y, d, br_n, last_bit;
    logic [WIDTH-1:0] sd_n;

    assign x        = sa[0];
    assign y        = sb[0];
    assign d        = x ^ y ^ br;
    assign br_n     = (~x & y) | (~(x ^ y) & br);
    // sd_n already contains the final bit on the last RUN cycle, so the
    // result register can be loaded from it directly.
    assign sd_n     = {d, sd[WIDTH-1:1]};
    assign last_bit = (cnt == LAST);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last_bit)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa       <= '0;
            sb       <= '0;
            sd       <= '0;
            br       <= 1'b0;
            cnt      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        sa  <= bus.a;
                        sb  <= bus.b;
                        br  <= 1'b0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    sd  <= sd_n;
                    br  <= br_n;
                    cnt <= cnt + 1'b1;
                    if (last_bit) begin
                        diff_q   <= sd_n;
                        borrow_q <= br_n;
                        cnt      <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- Flags ----------------
`ifdef SERIAL_SUB_FLAGS_EN
    logic a_msb, b_msb, v_q, z_q;

    // The operand MSBs are shifted out during RUN, so keep a copy for the
    // overflow test at completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            v_q   <= 1'b0;
            z_q   <= 1'b0;
        end else begin
            if (state_q == IDLE && bus.start) begin
                a_msb <= bus.a[WIDTH-1];
                b_msb <= bus.b[WIDTH-1];
            end
            if (state_q == RUN && last_bit) begin
                v_q <= (a_msb ^ b_msb) & (sd_n[WIDTH-1] ^ a_msb);
                z_q <= ~|sd_n;
            end
        end
    end

    assign bus.v = v_q;
    assign bus.z = z_q;
`else
    assign bus.v = 1'b0;
    assign bus.z = 1'b0;
`endif

    // ---------------- Outputs ----------------
    assign bus.busy   = (state_q == RUN);
    assign bus.done   = (state_q == DONE);
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W)) bus ();
    serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [W-1:0] diff;
        logic         borrow;
        logic         v;
        logic         z;
        int           acc;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_exp;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain arithmetic on the operand values.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
        exp_t e;
        longint sdiff;
        e.diff   = a - b;
        e.borrow = (a < b);
        sdiff    = longint'($signed(a)) - longint'($signed(b));
`ifdef SERIAL_SUB_FLAGS_EN
        e.v = (sdiff > 64'sd2147483647) || (sdiff < -64'sd2147483648);
        e.z = (e.diff == '0);
`else
        e.v = 1'b0;
        e.z = 1'b0;
`endif
        e.acc = acc;
        return e;
    endfunction

    // Monitor: checks every done pulse against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_done) chk("done_one_cycle", bus.done, 1'b0);
            if (bus.done && !prev_done) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", bus.done, 1'b0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("diff",    bus.diff,   e.diff);
                    chk("borrow",  bus.borrow, e.borrow);
                    chk("v",       bus.v,      e.v);
                    chk("z",       bus.z,      e.z);
                    chk("latency", 64'(cyc - e.acc), 64'(W));
                    last_exp = e;
                end
            end
            prev_done <= bus.done;
        end else begin
            prev_done <= 1'b0;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((bus.busy || bus.done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 1, 0);
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(sb_q.size()), 0);
        @(negedge clk);
    endtask

    // Issue one operation; start is dropped right after the accepting edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        wait_idle();
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        sb_q.push_back(model(a, b, cyc));
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        chk("busy_after_accept", bus.busy, 1'b1);
    endtask

    initial begin
        int acc0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",   bus.busy,   0);
        chk("rst_done",   bus.done,   0);
        chk("rst_diff",   bus.diff,   0);
        chk("rst_borrow", bus.borrow, 0);
        chk("rst_v",      bus.v,      0);
        chk("rst_z",      bus.z,      0);
        rst_n = 1'b1;

        // Directed boundary cases.
        run_op(32'd5, 32'd3);
        run_op(32'd0, 32'd1);
        run_op(32'h8000_0000, 32'h0000_0001);
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF);
        run_op(32'h0000_1234, 32'h0000_1234);
        drain();

        // Outputs hold through idle cycles.
        repeat (10) @(negedge clk);
        chk("hold_diff",   bus.diff,   last_exp.diff);
        chk("hold_borrow", bus.borrow, last_exp.borrow);
        chk("hold_z",      bus.z,      last_exp.z);
        chk("hold_done",   bus.done,   0);

        // Start held high: one operation per W+2 cycles.
        wait_idle();
        bus.start = 1'b1;
        bus.a     = 32'h0000_1234;
        bus.b     = 32'h0000_1200;
        @(negedge clk);
        acc0 = cyc;
        sb_q.push_back(model(32'h1234, 32'h1200, acc0));
        for (int i = 1; i < 3; i++) begin
            repeat (W + 2) @(negedge clk);
            sb_q.push_back(model(32'h1234, 32'h1200, acc0 + i * (W + 2)));
        end
        bus.start = 1'b0;
        drain();

        // start during RUN is ignored.
        run_op(32'd9, 32'd4);
        repeat (3) begin
            bus.start = 1'b1;
            bus.a     = 32'd1;
            @(negedge clk);
        end
        bus.start = 1'b0;
        drain();
        repeat (4) @(negedge clk);
        chk("no_retrigger", 64'(bus.busy), 0);

        // Reset in the middle of RUN aborts with no done pulse.
        run_op(32'd9, 32'd4);
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy",   bus.busy,   0);
        chk("abort_done",   bus.done,   0);
        chk("abort_diff",   bus.diff,   0);
        chk("abort_borrow", bus.borrow, 0);
        chk("abort_v",      bus.v,      0);
        chk("abort_z",      bus.z,      0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 4) @(negedge clk);
        chk("abort_no_done", bus.done, 0);
        run_op(32'd7, 32'd2);
        drain();

        // Randomized operations, mixing in edge values.
        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = ra;
                1: ra = 32'h8000_0000;
                2: rb = 32'h8000_0000;
                3: ra = '0;
                default: ;
            endcase
            run_op(ra, rb);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global guard against a hung run.
    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
